// File: rtl/nmcu_pkg.sv
// Shared NMCU types and dimension constants for the convolution datapath.
package nmcu_pkg;

    localparam int unsigned MAX_INPUT_DIM  = 15;
    localparam int unsigned MAX_KERNEL_DIM = 7;
    localparam int unsigned DATABUS_WIDTH  = 32;
    localparam int unsigned DIM_W          = $clog2(MAX_INPUT_DIM);
    localparam int unsigned KIDX_W         = $clog2(MAX_KERNEL_DIM);
    localparam int unsigned PROD_W         = 2 * DATABUS_WIDTH;

    typedef enum logic [1:0] {
        NOP,
        CONV,
        MAXP,
        RELU
    } nmcu_layer_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } conv_state_e;

    typedef logic [DIM_W-1:0]                 dim_t;
    typedef logic signed [DATABUS_WIDTH-1:0]  data_t;

    // A kernel that is empty, oversized, or does not fit the tile yields no output.
    function automatic logic kernel_invalid(input dim_t w, input dim_t h, input dim_t k);
        return (k == '0) || (k > DIM_W'(MAX_KERNEL_DIM)) || (k > w) || (k > h);
    endfunction

endpackage

// File: rtl/conv_for_nmcu_if.sv
// Request/result bundle between the NMCU controller and the CONV element.
interface conv_for_nmcu_if;
    import nmcu_pkg::*;

    logic  start;
    logic  done;
    dim_t  input_width;
    dim_t  input_height;
    dim_t  kernel_size;
    data_t local_kernel         [MAX_KERNEL_DIM][MAX_KERNEL_DIM];
    data_t local_activation_in  [MAX_INPUT_DIM][MAX_INPUT_DIM];
    data_t local_activation_out [MAX_INPUT_DIM][MAX_INPUT_DIM];

    modport master (
        output start,
        output input_width,
        output input_height,
        output kernel_size,
        output local_kernel,
        output local_activation_in,
        input  done,
        input  local_activation_out
    );

    modport slave (
        input  start,
        input  input_width,
        input  input_height,
        input  kernel_size,
        input  local_kernel,
        input  local_activation_in,
        output done,
        output local_activation_out
    );

endinterface

// File: rtl/nmcu_mac.sv
// Signed multiply-accumulate with synchronous clear; sum_c is acc + a*b for the
// current operands so the caller can capture a finished pixel without an extra cycle.
// Build option CONV_FOR_NMCU_SATURATE_EN clamps every add to the signed data range.
module nmcu_mac
    import nmcu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  clr,
    input  data_t a,
    input  data_t b,
    output data_t sum_c
);

    data_t acc_q;

`ifdef CONV_FOR_NMCU_SATURATE_EN
    localparam int unsigned WIDE_W = PROD_W + 1;
    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'({1'b0, {(DATABUS_WIDTH-1){1'b1}}});
    localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [WIDE_W-1:0] wide_c;

    assign prod_c = PROD_W'(a) * PROD_W'(b);
    assign wide_c = WIDE_W'(prod_c) + WIDE_W'(acc_q);

    // Clamp the full-precision sum into the representable range.
    always_comb begin
        sum_c = DATABUS_WIDTH'(wide_c);
        if (wide_c > SAT_MAX) begin
            sum_c = DATABUS_WIDTH'(SAT_MAX);
        end else if (wide_c < SAT_MIN) begin
            sum_c = DATABUS_WIDTH'(SAT_MIN);
        end
    end
`else
    // Low half of the signed product is all a wrapping accumulator needs.
    assign sum_c = acc_q + (a * b);
`endif

    // Accumulator register; clear has priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum_c;
        end
    end

endmodule

// File: rtl/conv_for_nmcu.sv
// Valid-mode, stride-1 2-D convolution, one kernel tap per clock.
// Output pixels row-major, taps row-major within a pixel; done is registered.
// Build option CONV_FOR_NMCU_SATURATE_EN selects saturating accumulation in nmcu_mac.
module conv_for_nmcu
    import nmcu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    conv_for_nmcu_if.slave bus
);

    conv_state_e       state_q;
    logic [DIM_W-1:0]  r_q;
    logic [DIM_W-1:0]  c_q;
    logic [DIM_W-1:0]  oh_m1_q;
    logic [DIM_W-1:0]  ow_m1_q;
    logic [KIDX_W-1:0] i_q;
    logic [KIDX_W-1:0] j_q;
    logic [KIDX_W-1:0] k_m1_q;
    logic              err_q;
    logic              fin_q;

    logic              accept_c;
    logic              run_c;
    logic              tap_last_c;
    logic              pix_last_c;
    logic [DIM_W-1:0]  act_row_c;
    logic [DIM_W-1:0]  act_col_c;
    data_t             tap_act_c;
    data_t             tap_kern_c;
    data_t             mac_sum_c;

    assign accept_c   = (state_q != CALC) && bus.start;
    assign run_c      = (state_q == CALC) && !err_q && !fin_q;
    assign tap_last_c = (i_q == k_m1_q) && (j_q == k_m1_q);
    assign pix_last_c = (r_q == oh_m1_q) && (c_q == ow_m1_q);
    assign act_row_c  = r_q + DIM_W'(i_q);
    assign act_col_c  = c_q + DIM_W'(j_q);
    assign tap_act_c  = bus.local_activation_in[act_row_c][act_col_c];
    assign tap_kern_c = bus.local_kernel[i_q][j_q];

    nmcu_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (run_c),
        .clr   (accept_c || (run_c && tap_last_c)),
        .a     (tap_act_c),
        .b     (tap_kern_c),
        .sum_c (mac_sum_c)
    );

    // Control FSM: accept a request, walk pixels and taps, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bus.done <= 1'b0;
            r_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            oh_m1_q  <= '0;
            ow_m1_q  <= '0;
            k_m1_q   <= '0;
            err_q    <= 1'b0;
            fin_q    <= 1'b0;
            for (int rr = 0; rr < int'(MAX_INPUT_DIM); rr++) begin
                for (int cc = 0; cc < int'(MAX_INPUT_DIM); cc++) begin
                    bus.local_activation_out[rr][cc] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q  <= CALC;
                        bus.done <= 1'b0;
                        r_q      <= '0;
                        c_q      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        oh_m1_q  <= bus.input_height - bus.kernel_size;
                        ow_m1_q  <= bus.input_width - bus.kernel_size;
                        k_m1_q   <= KIDX_W'(bus.kernel_size - DIM_W'(1));
                        err_q    <= kernel_invalid(bus.input_width, bus.input_height,
                                                   bus.kernel_size);
                        fin_q    <= 1'b0;
                        for (int rr = 0; rr < int'(MAX_INPUT_DIM); rr++) begin
                            for (int cc = 0; cc < int'(MAX_INPUT_DIM); cc++) begin
                                bus.local_activation_out[rr][cc] <= '0;
                            end
                        end
                    end
                end
                CALC: begin
                    if (err_q || fin_q) begin
                        // One settle cycle after the last tap (or a rejected kernel).
                        state_q  <= DONE;
                        bus.done <= 1'b1;
                    end else if (j_q != k_m1_q) begin
                        j_q <= j_q + KIDX_W'(1);
                    end else begin
                        j_q <= '0;
                        if (i_q != k_m1_q) begin
                            i_q <= i_q + KIDX_W'(1);
                        end else begin
                            i_q <= '0;
                            bus.local_activation_out[r_q][c_q] <= mac_sum_c;
                            if (c_q != ow_m1_q) begin
                                c_q <= c_q + DIM_W'(1);
                            end else begin
                                c_q <= '0;
                                if (r_q != oh_m1_q) begin
                                    r_q <= r_q + DIM_W'(1);
                                end else begin
                                    fin_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_for_nmcu.sv
// Self-checking bench for conv_for_nmcu: directed table, corner sequences, random runs.
module tb_conv_for_nmcu;
    import nmcu_pkg::*;

    localparam int NI       = MAX_INPUT_DIM;
    localparam int NK       = MAX_KERNEL_DIM;
    localparam int PAT_RAMP  = 0;
    localparam int PAT_CONST = 1;
    localparam int PAT_RAND  = 2;

`ifdef CONV_FOR_NMCU_SATURATE_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFE;
`endif

    typedef struct {
        string name;
        int    w;
        int    h;
        int    k;
        int    pat;
        data_t a_val;
        data_t k_val;
        int    exp_lat;
        bit    chk00;
        data_t exp00;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    data_t exp_out [NI][NI];
    vec_t  vecs [11];

    conv_for_nmcu_if bif ();

    conv_for_nmcu dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dims(input int w, input int h, input int k);
        bif.input_width  = DIM_W'(w);
        bif.input_height = DIM_W'(h);
        bif.kernel_size  = DIM_W'(k);
    endtask

    // Garbage everywhere, then the pattern inside the used region.
    task automatic fill(input int w, input int h, input int k, input int pat,
                        input data_t av, input data_t kv);
        for (int rr = 0; rr < NI; rr++)
            for (int cc = 0; cc < NI; cc++)
                bif.local_activation_in[rr][cc] = data_t'($urandom);
        for (int rr = 0; rr < NK; rr++)
            for (int cc = 0; cc < NK; cc++)
                bif.local_kernel[rr][cc] = data_t'($urandom);
        for (int rr = 0; rr < h; rr++)
            for (int cc = 0; cc < w; cc++)
                case (pat)
                    PAT_RAMP:  bif.local_activation_in[rr][cc] = data_t'(rr * w + cc + 1);
                    PAT_CONST: bif.local_activation_in[rr][cc] = av;
                    default:   bif.local_activation_in[rr][cc] = data_t'($urandom);
                endcase
        for (int rr = 0; rr < k && rr < NK; rr++)
            for (int cc = 0; cc < k && cc < NK; cc++)
                case (pat)
                    PAT_RAMP:  bif.local_kernel[rr][cc] = 32'sd1;
                    PAT_CONST: bif.local_kernel[rr][cc] = kv;
                    default:   bif.local_kernel[rr][cc] = data_t'($urandom);
                endcase
    endtask

    // Reference: plain convolution sum over 64-bit products.
    task automatic model(input int w, input int h, input int k);
        longint acc;
        for (int rr = 0; rr < NI; rr++)
            for (int cc = 0; cc < NI; cc++)
                exp_out[rr][cc] = '0;
        if (k < 1 || k > NK || k > w || k > h) return;
        for (int r = 0; r <= h - k; r++)
            for (int c = 0; c <= w - k; c++) begin
                acc = 0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++) begin
                        acc += longint'(bif.local_activation_in[r+i][c+j]) *
                               longint'(bif.local_kernel[i][j]);
`ifdef CONV_FOR_NMCU_SATURATE_EN
                        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
                        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
                    end
                exp_out[r][c] = data_t'(acc);
            end
    endtask

    function automatic int exp_latency(input int w, input int h, input int k);
        if (k < 1 || k > NK || k > w || k > h) return 1;
        return 1 + (h - k + 1) * (w - k + 1) * k * k;
    endfunction

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (bif.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bif.done !== 1'b1) n = -1;
    endtask

    task automatic run(input int w, input int h, input int k, output int lat);
        set_dims(w, h, k);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        wait_done(6000, lat);
    endtask

    task automatic cmp_outs(input string name);
        int nbad = 0;
        int fr = 0;
        int fc = 0;
        for (int rr = 0; rr < NI; rr++)
            for (int cc = 0; cc < NI; cc++)
                if (bif.local_activation_out[rr][cc] !== exp_out[rr][cc]) begin
                    if (nbad == 0) begin
                        fr = rr;
                        fc = cc;
                    end
                    nbad++;
                end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d entries differ, first [%0d][%0d] got %h want %h",
                     name, nbad, fr, fc, bif.local_activation_out[fr][fc], exp_out[fr][fc]);
        end
    endtask

    initial begin
        int lat;
        int m;
        int w;
        int h;
        int k;

        vecs[0]  = '{"basic",      3,  3, 2, PAT_RAMP,  32'sd0,           32'sd0, 17,   1'b1, 32'sd12};
        vecs[1]  = '{"identity",   4,  4, 1, PAT_RAMP,  32'sd0,           32'sd0, 17,   1'b1, 32'sd1};
        vecs[2]  = '{"signed",     1,  1, 1, PAT_CONST, -32'sd3,          32'sd5, 2,    1'b1, -32'sd15};
        vecs[3]  = '{"oversize",   2,  2, 3, PAT_RAMP,  32'sd0,           32'sd0, 1,    1'b1, 32'sd0};
        vecs[4]  = '{"overflow",   1,  1, 1, PAT_CONST, 32'sh7FFF_FFFF,   32'sd2, 2,    1'b1, data_t'(OVF_EXP)};
        vecs[5]  = '{"k_zero",     5,  5, 0, PAT_RAND,  32'sd0,           32'sd0, 1,    1'b1, 32'sd0};
        vecs[6]  = '{"k_over_max", 15, 15, 8, PAT_RAND, 32'sd0,           32'sd0, 1,    1'b1, 32'sd0};
        vecs[7]  = '{"full7",      7,  7, 7, PAT_RAND,  32'sd0,           32'sd0, 50,   1'b0, 32'sd0};
        vecs[8]  = '{"big",        15, 15, 3, PAT_RAND, 32'sd0,           32'sd0, 1522, 1'b0, 32'sd0};
        vecs[9]  = '{"wide_row",   15, 1, 1, PAT_RAND,  32'sd0,           32'sd0, 16,   1'b0, 32'sd0};
        vecs[10] = '{"tall",       5,  9, 5, PAT_RAND,  32'sd0,           32'sd0, 126,  1'b0, 32'sd0};

        rst       = 1'b1;
        bif.start = 1'b0;
        set_dims(0, 0, 0);
        fill(0, 0, 0, PAT_RAND, '0, '0);
        tick();
        tick();
        check("reset_done", 32'(bif.done), 32'd0);
        model(0, 0, 0);
        cmp_outs("reset_outs");
        rst = 1'b0;
        tick();

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            fill(vecs[v].w, vecs[v].h, vecs[v].k, vecs[v].pat, vecs[v].a_val, vecs[v].k_val);
            model(vecs[v].w, vecs[v].h, vecs[v].k);
            run(vecs[v].w, vecs[v].h, vecs[v].k, lat);
            check({vecs[v].name, "_lat"}, 32'(lat), 32'(vecs[v].exp_lat));
            cmp_outs({vecs[v].name, "_outs"});
            if (vecs[v].chk00)
                check({vecs[v].name, "_out00"}, bif.local_activation_out[0][0], vecs[v].exp00);
        end

        // Basic case: per-pixel write timing, start ignored mid-run, hold in DONE.
        fill(3, 3, 2, PAT_RAMP, '0, '0);
        set_dims(3, 3, 2);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        tick(); tick(); tick();
        check("out00_before_last_tap", bif.local_activation_out[0][0], 32'd0);
        tick();
        check("out00_on_last_tap", bif.local_activation_out[0][0], 32'd12);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        wait_done(100, m);
        check("lat_start_ignored", 32'(m < 0 ? -1 : 5 + m), 32'd17);
        check("basic_out01", bif.local_activation_out[0][1], 32'd16);
        check("basic_out10", bif.local_activation_out[1][0], 32'd24);
        check("basic_out11", bif.local_activation_out[1][1], 32'd28);
        check("basic_out22", bif.local_activation_out[2][2], 32'd0);
        repeat (5) tick();
        check("done_held", 32'(bif.done), 32'd1);
        check("out11_held", bif.local_activation_out[1][1], 32'd28);

        // Restart from DONE clears outputs and done on the start edge.
        set_dims(2, 2, 3);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        check("restart_done_clr", 32'(bif.done), 32'd0);
        check("restart_out_clr", bif.local_activation_out[1][1], 32'd0);
        tick();
        check("restart_err_done", 32'(bif.done), 32'd1);

        // Asynchronous reset mid-run, then a clean rerun.
        fill(3, 3, 2, PAT_RAMP, '0, '0);
        set_dims(3, 3, 2);
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_done", 32'(bif.done), 32'd0);
        check("rst_mid_out00", bif.local_activation_out[0][0], 32'd0);
        model(0, 0, 0);
        cmp_outs("rst_mid_outs");
        tick();
        rst = 1'b0;
        tick();
        model(3, 3, 2);
        run(3, 3, 2, lat);
        check("rerun_lat", 32'(lat), 32'd17);
        cmp_outs("rerun_outs");

        // Random shapes and data against the reference.
        for (int n = 0; n < 15; n++) begin
            w = int'($urandom_range(1, 12));
            h = int'($urandom_range(1, 12));
            k = int'($urandom_range(0, 5));
            fill(w, h, k, PAT_RAND, '0, '0);
            model(w, h, k);
            run(w, h, k, lat);
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'(exp_latency(w, h, k)));
            cmp_outs($sformatf("rand%0d_outs_w%0d_h%0d_k%0d", n, w, h, k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_for_nmcu.md
# conv_for_nmcu

Sequential 2-D convolution processing element of the near-memory compute unit (NMCU). It takes a locally buffered activation tile and a square kernel, computes a valid-mode (no padding, stride 1) convolution with one multiply-accumulate per clock, and writes the result into an output tile. The NMCU controller instantiates it for CONV layers, then waits for `done`.

## Interface
- `MAX_INPUT_DIM`, 15: maximum activation rows and columns.
- `MAX_KERNEL_DIM`, 7: maximum kernel side.
- `DATABUS_WIDTH`, 32: element width, signed two's complement.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level-sampled request to begin.
- `done`  out  1  high when the result is valid.
- `input_width`  in  $clog2(MAX_INPUT_DIM)  activation columns W.
- `input_height`  in  $clog2(MAX_INPUT_DIM)  activation rows H.
- `kernel_size`  in  $clog2(MAX_INPUT_DIM)  kernel side K.
- `local_kernel`  in  DATABUS_WIDTH × [MAX_KERNEL_DIM][MAX_KERNEL_DIM]  indexed [row][col].
- `local_activation_in`  in  DATABUS_WIDTH × [MAX_INPUT_DIM][MAX_INPUT_DIM]  indexed [row][col].
- `local_activation_out`  out  DATABUS_WIDTH × [MAX_INPUT_DIM][MAX_INPUT_DIM]  result array, indexed [row][col].

## Operation
- States: IDLE, CALC, DONE.
- On `start` in IDLE or DONE:
  - Latch W, H and K.
  - Clear every element of `local_activation_out` to 0.
  - Clear `done`.
  - Go to CALC.
- Error case: if K == 0, K > MAX_KERNEL_DIM, K > W or K > H, go straight to DONE. The outputs stay all-zero.
- Output size: OH = H−K+1 rows, OW = W−K+1 columns.
- Result definition: out[r][c] = Σ in[r+i][c+j] · k[i][j] for i, j in 0..K−1.
- Entries outside OH×OW stay 0.
- Iteration order in CALC:
  - Output pixels in row-major order (r outer, c inner).
  - Within each pixel, kernel taps in row-major order (i outer, j inner).
  - One tap per cycle.
- Arithmetic:
  - The product is a signed DATABUS_WIDTH×DATABUS_WIDTH multiply.
  - The accumulator is DATABUS_WIDTH bits and wraps modulo 2^DATABUS_WIDTH; the low DATABUS_WIDTH bits are kept.
- On a pixel's last tap, write (acc + product) into out[r][c] and clear the accumulator.
- After the last tap of the last pixel, go to DONE and assert `done`.
- DONE holds `done` = 1 and holds the outputs until the next `start` or reset.
- `start` during CALC is ignored.
- The kernel and activation arrays are not latched. The driver must hold them stable from `start` until `done`.

## Timing
- Reset values: `done` = 0, all `local_activation_out` = 0, state IDLE, accumulator and counters 0.
- Reset is asynchronous and takes effect immediately, including mid-CALC. A partial result is discarded.
- Latency, valid case: `done` rises on the (1 + OH·OW·K²)-th rising edge after the edge that samples `start`.
- Latency, error case: `done` rises on the first edge after the `start` edge.
- out[r][c] becomes valid on the edge that processes its last tap. Each output is written exactly once per run.

## Configuration
- `CONV_FOR_NMCU_SATURATE_EN`:
  - Defined: accumulation is computed wide and clamped on every add to [−2^(DATABUS_WIDTH−1), 2^(DATABUS_WIDTH−1)−1].
  - Undefined: modulo-wrap arithmetic as specified above.
- Latency is identical in both builds.

## Structure
- Package `nmcu_pkg` holds:
  - the NMCU layer-type enum (NOP, CONV, MAXP, RELU);
  - this block's state enum (IDLE, CALC, DONE);
  - the default dimension constants.
- One sub-module, `nmcu_mac`: a registered signed multiply-accumulate with clear, and saturation under the macro.
- Control (counters r, c, i, j and the FSM) lives in `conv_for_nmcu`.

## Test plan
- Basic 3×3 convolution:
  - Stimulus: 3×3 input 1..9 in row-major order, 2×2 kernel of all 1s, pulse `start`.
  - Response: out[0][0]=12, [0][1]=16, [1][0]=24, [1][1]=28; all other entries 0; `done` on edge 17.
- 1×1 identity:
  - Stimulus: K=1, kernel 1, 4×4 input.
  - Response: output equals input; `done` on edge 17.
- Signed values:
  - Stimulus: 1×1 input −3, K=1, kernel 5.
  - Response: out[0][0] = −15 (0xFFFFFFF1).
- Oversized kernel:
  - Stimulus: K=3 with a 2×2 input.
  - Response: `done` on the next edge; all outputs 0.
- Overflow behaviour:
  - Stimulus: 1×1 input 0x7FFFFFFF, kernel 2.
  - Response without macro: 0xFFFFFFFE.
  - Response with `CONV_FOR_NMCU_SATURATE_EN`: 0x7FFFFFFF.
- Reset and restart:
  - Stimulus: assert `rst` mid-CALC of the basic case, then restart.
  - Response: immediately after `rst`, `done`=0 and outputs 0; the restart reproduces the basic-case result with identical latency.
